mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 43 ++++
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_lane_merge.sv | 30 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, access sizes,
// the latched request payload and the alignment check.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NPORT  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        size_e             size;
    } mem_req_t;

    // True when the access cannot be served: illegal size or unaligned address.
    function automatic logic misaligned(input size_e size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offset[0];
            SIZE_W:  bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, response and RAM data-port signals of the memory arbiter.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic [NPORT-1:0]             req_valid;
    logic [NPORT-1:0]             req_ready;
    logic [NPORT-1:0][ADDR_W-1:0] req_addr;
    logic [NPORT-1:0][DATA_W-1:0] req_wdata;
    logic [NPORT-1:0]             req_we;
    logic [NPORT-1:0][1:0]        req_size;

    logic [NPORT-1:0]             rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;

    logic                         ram_en;
    logic                         ram_wr;
    logic [ADDR_W-1:0]            ram_addr;
    logic [DATA_W-1:0]            ram_wdata;
    logic [DATA_W-1:0]            ram_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_size, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               ram_en, ram_wr, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_size, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               ram_en, ram_wr, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_lane_merge.sv
// Byte-lane helper: merges sub-word store data into the old RAM word and
// extracts right-aligned, zero-extended load data from a RAM word.
module mem_lane_merge
    import mem_arb_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        offset,
    input  size_e             size,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] extracted
);

    logic [DATA_W-1:0] size_mask;
    logic [DATA_W-1:0] lane_mask;
    logic [4:0]        shamt;

    always_comb begin
        shamt = {offset, 3'b000};
        case (size)
            SIZE_B:  size_mask = DATA_W'(32'h0000_00FF);
            SIZE_H:  size_mask = DATA_W'(32'h0000_FFFF);
            default: size_mask = '1;
        endcase
        lane_mask = size_mask << shamt;
        merged    = (old_word & ~lane_mask) | ((wdata << shamt) & lane_mask);
        extracted = (old_word >> shamt) & size_mask;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word RAM, with
// read-modify-write for byte/half stores and misalignment error responses.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    state_e            state;
    state_e            next_state;
    mem_req_t          req_q;
    mem_req_t          grant_req;
    logic              port_q;
    logic              err_q;
    logic              last_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant_port;
    logic [NPORT-1:0]  grant_c;
    logic              accept_c;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] extracted;

    logic              ram_en_c;
    logic              ram_wr_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic [NPORT-1:0]  rsp_valid_c;
    logic [DATA_W-1:0] rsp_rdata_c;
    logic              rsp_err_c;

    // Round-robin grant: with both valid, favour the port not served last.
    always_comb begin
        grant_c    = '0;
        grant_port = 1'b0;
        if (state == IDLE && !rst) begin
            grant_port          = (&bus.req_valid) ? ~last_q : bus.req_valid[1];
            grant_c[grant_port] = |bus.req_valid;
        end
    end

    assign bus.req_ready = grant_c;
    assign accept_c      = |grant_c;

    always_comb begin
        grant_req.addr  = bus.req_addr[grant_port];
        grant_req.wdata = bus.req_wdata[grant_port];
        grant_req.we    = bus.req_we[grant_port];
        grant_req.size  = size_e'(bus.req_size[grant_port]);
    end

    mem_lane_merge u_lane (
        .old_word  (bus.ram_rdata),
        .wdata     (req_q.wdata),
        .offset    (req_q.addr[1:0]),
        .size      (req_q.size),
        .merged    (merged),
        .extracted (extracted)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_c)
                    next_state = misaligned(grant_req.size, grant_req.addr[1:0]) ? RESP : ACCESS;
            end
            ACCESS:  next_state = (req_q.we && req_q.size == SIZE_W) ? RESP : WAIT;
            WAIT:    next_state = req_q.we ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction context, frozen at acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            port_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            if (accept_c) begin
                req_q   <= grant_req;
                port_q  <= grant_port;
                last_q  <= grant_port;
                err_q   <= misaligned(grant_req.size, grant_req.addr[1:0]);
                rdata_q <= '0;
            end
            if (state == WAIT && !req_q.we)
                rdata_q <= extracted;
        end
    end

    // RAM strobes are computed from the upcoming state so they register into it.
    always_comb begin
        ram_en_c    = 1'b0;
        ram_wr_c    = 1'b0;
        ram_addr_c  = '0;
        ram_wdata_c = '0;
        rsp_valid_c = '0;
        rsp_rdata_c = '0;
        rsp_err_c   = 1'b0;
        case (next_state)
            ACCESS: begin
                ram_en_c   = 1'b1;
                ram_addr_c = {grant_req.addr[ADDR_W-1:2], 2'b00};
                if (grant_req.we && grant_req.size == SIZE_W) begin
                    ram_wr_c    = 1'b1;
                    ram_wdata_c = grant_req.wdata;
                end
            end
            WRITE: begin
                ram_en_c    = 1'b1;
                ram_wr_c    = 1'b1;
                ram_addr_c  = {req_q.addr[ADDR_W-1:2], 2'b00};
                ram_wdata_c = merged;
            end
            default: ;
        endcase
        if (state == RESP) begin
            rsp_valid_c[port_q] = 1'b1;
            rsp_rdata_c         = rdata_q;
            rsp_err_c           = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ram_en    <= 1'b0;
            bus.ram_wr    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.ram_en    <= ram_en_c;
            bus.ram_wr    <= ram_wr_c;
            bus.ram_addr  <= ram_addr_c;
            bus.ram_wdata <= ram_wdata_c;
            bus.rsp_valid <= rsp_valid_c;
            bus.rsp_rdata <= rsp_rdata_c;
            bus.rsp_err   <= rsp_err_c;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, byte-level memory model and
// transaction-level expectations for grants, latency, data and errors.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [0:1023];
    logic        bd_we;
    logic [9:0]  bd_idx;
    logic [31:0] bd_data;

    // Word RAM with one-cycle read latency and a backdoor write port.
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_idx] <= bd_data;
        end else if (bus.ram_en) begin
            if (bus.ram_wr) ram[bus.ram_addr[11:2]] <= bus.ram_wdata;
            bus.ram_rdata <= ram[bus.ram_addr[11:2]];
        end
    end

    logic [7:0]  mbytes [0:4095];
    logic [31:0] cur_addr  [2];
    logic [31:0] cur_wdata [2];
    logic        cur_we    [2];
    logic [1:0]  cur_size  [2];
    logic        model_last;
    int          n_checks = 0;
    int          n_fail   = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic bd_write(input int idx, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_idx  = 10'(idx);
        bd_data = data;
        for (int b = 0; b < 4; b++) mbytes[idx*4 + b] = data[8*b +: 8];
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] w,
                           input logic we, input logic [1:0] sz);
        cur_addr[p] = a; cur_wdata[p] = w; cur_we[p] = we; cur_size[p] = sz;
        bus.req_addr[p] = a; bus.req_wdata[p] = w; bus.req_we[p] = we; bus.req_size[p] = sz;
    endtask

    task automatic rand_req(input int p);
        logic [31:0] a;
        logic [1:0]  sz;
        int          nb;
        sz = 2'($urandom_range(0, 3));
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a  = 32'($urandom_range(0, 4095));
        if ($urandom_range(0, 2) != 0) a = a & ~32'(nb - 1);
        set_req(p, a, $urandom, 1'($urandom_range(0, 1)), sz);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    // One request from acceptance to response, checked against the byte model.
    task automatic run_one(input logic [1:0] mask, input bit hold, output int gp,
                           output int o_lat, output logic [31:0] o_rdata,
                           output logic o_err, output int o_en);
        logic [1:0]  exp_ready;
        logic [31:0] a_addr, a_wdata, e_rdata, exp_word;
        logic        a_we, e_err;
        logic [1:0]  a_size;
        int          ep, nb, off, base, e_lat, e_en, e_wr, n_wr, waited;
        bit          seen;
        gp = -1; o_lat = -1; o_rdata = '0; o_err = 1'b0; o_en = 0; n_wr = 0;
        bus.req_valid = mask;
        #1;
        waited = 0;
        while (bus.req_ready == 2'b00 && waited < 10) begin
            @(negedge clk); #1; waited++;
        end
        ep = (mask == 2'b11) ? (model_last ? 0 : 1) : (mask[1] ? 1 : 0);
        exp_ready = 2'b00;
        exp_ready[ep] = 1'b1;
        n_checks++;
        if (bus.req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL grant: req_ready=%b expected %b (valid=%b)", bus.req_ready, exp_ready, mask);
            bus.req_valid = 2'b00;
            return;
        end
        a_addr = cur_addr[ep]; a_wdata = cur_wdata[ep]; a_we = cur_we[ep]; a_size = cur_size[ep];
        nb    = (a_size == 2'd0) ? 1 : (a_size == 2'd1) ? 2 : (a_size == 2'd2) ? 4 : 0;
        e_err = (nb == 0) ? 1'b1 : ((a_addr % 32'(nb)) != 32'd0);
        base  = int'(a_addr[11:0]) & ~3;
        off   = int'(a_addr[1:0]);
        e_lat = e_err ? 1 : (!a_we ? 3 : (nb == 4 ? 2 : 4));
        e_en  = e_err ? 0 : ((a_we && nb != 4) ? 2 : 1);
        e_wr  = (e_err || !a_we) ? 0 : 1;
        e_rdata = '0;
        if (!e_err && !a_we)
            for (int b = 0; b < nb; b++) e_rdata[8*b +: 8] = mbytes[base + off + b];

        @(posedge clk);
        #1;
        if (!hold) begin
            bus.req_valid[ep] = 1'b0;
            bus.req_addr[ep]  = $urandom;
            bus.req_wdata[ep] = $urandom;
            bus.req_we[ep]    = 1'($urandom_range(0, 1));
            bus.req_size[ep]  = 2'($urandom_range(0, 3));
        end
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.ram_en) o_en++;
            if (bus.ram_en && bus.ram_wr) n_wr++;
            if (bus.rsp_valid != 2'b00) begin
                seen = 1'b1; o_lat = k; o_rdata = bus.rsp_rdata; o_err = bus.rsp_err;
                n_checks++;
                if (bus.rsp_valid !== exp_ready) begin
                    n_fail++;
                    $display("FAIL rsp_port: rsp_valid=%b expected %b", bus.rsp_valid, exp_ready);
                end
            end
        end
        n_checks++;
        if (o_lat != e_lat) begin
            n_fail++;
            $display("FAIL latency: addr=%h we=%b size=%0d got %0d expected %0d", a_addr, a_we, a_size, o_lat, e_lat);
        end
        n_checks++;
        if (o_err !== e_err || o_rdata !== e_rdata) begin
            n_fail++;
            $display("FAIL response: addr=%h err=%b rdata=%h expected err=%b rdata=%h", a_addr, o_err, o_rdata, e_err, e_rdata);
        end
        n_checks++;
        if (o_en != e_en || n_wr != e_wr) begin
            n_fail++;
            $display("FAIL ram_strobes: addr=%h en_cycles=%0d wr_cycles=%0d expected %0d/%0d", a_addr, o_en, n_wr, e_en, e_wr);
        end
        if (!e_err && a_we)
            for (int b = 0; b < nb; b++) mbytes[base + off + b] = a_wdata[8*b +: 8];
        exp_word = {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
        n_checks++;
        if (ram[base >> 2] !== exp_word) begin
            n_fail++;
            $display("FAIL memory: word %h holds %h expected %h", base, ram[base >> 2], exp_word);
        end
        model_last = ep[0];
        gp = ep;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rand_req(0); rand_req(1);
        bus.req_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: ready=%b rsp_valid=%b err=%b expected 00/00/0", bus.req_ready, bus.rsp_valid, bus.rsp_err);
        end
        n_checks++;
        if (bus.ram_en !== 1'b0 || bus.ram_wr !== 1'b0 || bus.ram_addr !== 32'h0 ||
            bus.ram_wdata !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: en=%b wr=%b addr=%h wdata=%h rdata=%h expected all zero", bus.ram_en, bus.ram_wr, bus.ram_addr, bus.ram_wdata, bus.rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 2'b00;
        model_last = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.ram_en !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_quiet: en=%b rsp_valid=%b ready=%b expected 0/00/00", bus.ram_en, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_round_robin();
        int gp, lat, en;
        logic [31:0] rd;
        logic er;
        apply_reset();
        set_req(0, 32'h010, 32'h0, 1'b0, 2'd2);
        set_req(1, 32'h020, 32'h0, 1'b0, 2'd2);
        for (int g = 0; g < 4; g++) begin
            run_one(2'b11, 1'b1, gp, lat, rd, er, en);
            n_checks++;
            if (gp != g % 2) begin
                n_fail++;
                $display("FAIL rr_order: grant %0d went to port %0d expected %0d", g, gp, g % 2);
            end
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_word_load();
        int gp, lat, en;
        logic [31:0] rd;
        logic er;
        bd_write(32'h100 >> 2, 32'hDEADBEEF);
        set_req(0, 32'h100, 32'h0, 1'b0, 2'd2);
        run_one(2'b01, 1'b0, gp, lat, rd, er, en);
        n_checks++;
        if (lat != 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL word_load: lat=%0d rdata=%h err=%b expected 3/deadbeef/0", lat, rd, er);
        end
    endtask

    task automatic test_byte_store();
        int gp, lat, en;
        logic [31:0] rd;
        logic er;
        bd_write(32'h200 >> 2, 32'h11223344);
        set_req(1, 32'h203, 32'h000000AA, 1'b1, 2'd0);
        run_one(2'b10, 1'b0, gp, lat, rd, er, en);
        n_checks++;
        if (lat != 4 || ram[32'h200 >> 2] !== 32'hAA223344 || gp != 1) begin
            n_fail++;
            $display("FAIL byte_store: lat=%0d word=%h port=%0d expected 4/aa223344/1", lat, ram[32'h200 >> 2], gp);
        end
    endtask

    task automatic test_misaligned();
        int gp, lat, en;
        logic [31:0] rd;
        logic er;
        set_req(0, 32'h101, 32'h0, 1'b0, 2'd1);
        run_one(2'b01, 1'b0, gp, lat, rd, er, en);
        n_checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || en != 0) begin
            n_fail++;
            $display("FAIL misaligned: lat=%0d err=%b rdata=%h en_cycles=%0d expected 1/1/0/0", lat, er, rd, en);
        end
    endtask

    task automatic test_half_load();
        int gp, lat, en;
        logic [31:0] rd;
        logic er;
        bd_write(32'h300 >> 2, 32'hCAFE1234);
        set_req(0, 32'h302, 32'h0, 1'b0, 2'd1);
        run_one(2'b01, 1'b0, gp, lat, rd, er, en);
        n_checks++;
        if (rd !== 32'h0000CAFE || er !== 1'b0) begin
            n_fail++;
            $display("FAIL half_load: rdata=%h err=%b expected 0000cafe/0", rd, er);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL rsp_pulse: rsp_valid=%b one cycle later, expected 00", bus.rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int waited, n_rsp, n_wr;
        bd_write(32'h400 >> 2, 32'h55667788);
        set_req(0, 32'h401, 32'h00000099, 1'b1, 2'd0);
        bus.req_valid = 2'b01;
        #1;
        waited = 0;
        while (bus.req_ready[0] !== 1'b1 && waited < 10) begin
            @(negedge clk); #1; waited++;
        end
        n_checks++;
        if (bus.req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_grant: req_ready=%b expected 01", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        n_rsp = 0; n_wr = 0;
        @(negedge clk);
        if (bus.rsp_valid != 2'b00) n_rsp++;
        if (bus.ram_en && bus.ram_wr) n_wr++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        if (bus.rsp_valid != 2'b00) n_rsp++;
        set_req(1, 32'h500, 32'h0, 1'b0, 2'd2);
        bus.req_valid = 2'b10;
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_idle: req_ready=%b after reset, expected 10", bus.req_ready);
        end
        bus.req_valid = 2'b00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) n_rsp++;
            if (bus.ram_en && bus.ram_wr) n_wr++;
        end
        n_checks++;
        if (n_rsp != 0 || n_wr != 0 || ram[32'h400 >> 2] !== 32'h55667788) begin
            n_fail++;
            $display("FAIL abort: rsp=%0d writes=%0d word=%h expected 0/0/55667788", n_rsp, n_wr, ram[32'h400 >> 2]);
        end
    endtask

    task automatic test_random();
        logic [1:0]  pending;
        int          gp, lat, en;
        logic [31:0] rd;
        logic        er;
        pending = 2'b00;
        for (int it = 0; it < 60; it++) begin
            for (int p = 0; p < 2; p++)
                if (!pending[p] && $urandom_range(0, 1) == 1) begin
                    rand_req(p);
                    pending[p] = 1'b1;
                end
            if (pending == 2'b00) begin
                gp = int'($urandom_range(0, 1));
                rand_req(gp);
                pending[gp] = 1'b1;
            end
            run_one(pending, 1'b0, gp, lat, rd, er, en);
            if (gp >= 0) pending[gp] = 1'b0;
            else pending = 2'b00;
        end
        while (pending != 2'b00) begin
            run_one(pending, 1'b0, gp, lat, rd, er, en);
            if (gp >= 0) pending[gp] = 1'b0;
            else pending = 2'b00;
        end
        bus.req_valid = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        model_last = 1'b1;
        bus.req_valid = 2'b00;
        set_req(0, 32'h0, 32'h0, 1'b0, 2'd0);
        set_req(1, 32'h0, 32'h0, 1'b0, 2'd0);
        @(negedge clk);
        for (int i = 0; i < 1024; i++) bd_write(i, $urandom);
        test_reset();
        test_round_robin();
        test_word_load();
        test_byte_store();
        test_misaligned();
        test_half_load();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
